// File: rtl/wave_ctrl_dds_if.sv
// Waveform select in, DAC sample out; the board selector drives master, the DDS core is slave.
// Purely combinational wires; no flow control, the DAC accepts one sample every clock.
interface wave_ctrl_dds_if;
    logic [3:0] wave_sel;
    logic [7:0] dac_data;

    modport master (output wave_sel, input dac_data);
    modport slave  (input wave_sel, output dac_data);
endinterface

// File: rtl/wave_ctrl_dds.sv
// DDS generator: 32-bit phase accumulator indexes sine/square/triangle/sawtooth into an 8-bit DAC.
// Latency: one register stage (select latency 1 edge, 3 edges with WAVE_SEL_REG_EN synchronizer).
// Backpressure: none, free-running; a new sample is produced on every sys_clk edge.
module wave_ctrl_dds #(
    parameter logic [31:0] FREQ_CTRL  = 32'd42949,
    parameter logic [7:0]  PHASE_CTRL = 8'd0
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    wave_ctrl_dds_if.slave bus
);

    logic [31:0] phase_acc;
    logic [3:0]  sel;
    logic [7:0]  idx;
    logic [5:0]  qidx;
    logic [6:0]  mag;
    logic [7:0]  sine_val;
    logic [7:0]  sample;

`ifdef WAVE_SEL_REG_EN
    logic [3:0] sel_meta;
    logic [3:0] sel_sync;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sel_meta <= 4'b0000;
            sel_sync <= 4'b0000;
        end else begin
            sel_meta <= bus.wave_sel;
            sel_sync <= sel_meta;
        end
    end

    assign sel = sel_sync;
`else
    assign sel = bus.wave_sel;
`endif

    // round(127*sin(2*pi*k/256)) for k = 0..63; k = 64 (the peak) is handled by the caller
    function automatic logic [6:0] quarter_sine(input logic [5:0] k);
        case (k)
            6'd0:  return 7'd0;   6'd1:  return 7'd3;   6'd2:  return 7'd6;   6'd3:  return 7'd9;
            6'd4:  return 7'd12;  6'd5:  return 7'd16;  6'd6:  return 7'd19;  6'd7:  return 7'd22;
            6'd8:  return 7'd25;  6'd9:  return 7'd28;  6'd10: return 7'd31;  6'd11: return 7'd34;
            6'd12: return 7'd37;  6'd13: return 7'd40;  6'd14: return 7'd43;  6'd15: return 7'd46;
            6'd16: return 7'd49;  6'd17: return 7'd51;  6'd18: return 7'd54;  6'd19: return 7'd57;
            6'd20: return 7'd60;  6'd21: return 7'd63;  6'd22: return 7'd65;  6'd23: return 7'd68;
            6'd24: return 7'd71;  6'd25: return 7'd73;  6'd26: return 7'd76;  6'd27: return 7'd78;
            6'd28: return 7'd81;  6'd29: return 7'd83;  6'd30: return 7'd85;  6'd31: return 7'd88;
            6'd32: return 7'd90;  6'd33: return 7'd92;  6'd34: return 7'd94;  6'd35: return 7'd96;
            6'd36: return 7'd98;  6'd37: return 7'd100; 6'd38: return 7'd102; 6'd39: return 7'd104;
            6'd40: return 7'd106; 6'd41: return 7'd107; 6'd42: return 7'd109; 6'd43: return 7'd111;
            6'd44: return 7'd112; 6'd45: return 7'd113; 6'd46: return 7'd115; 6'd47: return 7'd116;
            6'd48: return 7'd117; 6'd49: return 7'd118; 6'd50: return 7'd120; 6'd51: return 7'd121;
            6'd52: return 7'd122; 6'd53: return 7'd122; 6'd54: return 7'd123; 6'd55: return 7'd124;
            6'd56: return 7'd125; 6'd57: return 7'd125; 6'd58: return 7'd126; 6'd59: return 7'd126;
            6'd60: return 7'd126; 6'd61: return 7'd127; 6'd62: return 7'd127; default: return 7'd127;
        endcase
    endfunction

    assign idx  = phase_acc[31:24] + PHASE_CTRL;
    assign qidx = idx[6] ? (6'd0 - idx[5:0]) : idx[5:0];

    always_comb begin
        mag = quarter_sine(qidx);
        // Falling quarter at offset 0 is the crest itself, which the 64-entry table cannot address
        if (idx[6] && (idx[5:0] == 6'd0)) begin
            mag = 7'd127;
        end
        sine_val = idx[7] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
    end

    always_comb begin
        sample = 8'd0;
        case (sel)
            4'b0001: sample = sine_val;
            4'b0010: sample = idx[7] ? 8'd0 : 8'd255;
            4'b0100: sample = idx[7] ? {~idx[6:0], 1'b0} : {idx[6:0], 1'b0};
            4'b1000: sample = idx;
            default: sample = 8'd0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            phase_acc    <= 32'd0;
            bus.dac_data <= 8'd0;
        end else begin
            phase_acc    <= phase_acc + FREQ_CTRL;
            bus.dac_data <= sample;
        end
    end

endmodule

// File: tb/tb_wave_ctrl_dds.sv
// Scoreboard bench for wave_ctrl_dds: three instances (ramp-rate, phase-offset, nominal rate)
// share clock, reset and select; a reference model queues expected samples per instance.
module tb_wave_ctrl_dds;

`ifdef WAVE_SEL_REG_EN
    localparam int SEL_DLY = 2;
`else
    localparam int SEL_DLY = 0;
`endif

    localparam logic [31:0] F0 = 32'h0100_0000;
    localparam logic [31:0] F2 = 32'd42949;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] sel;

    always #5 sys_clk = ~sys_clk;

    wave_ctrl_dds_if bus0 ();
    wave_ctrl_dds_if bus1 ();
    wave_ctrl_dds_if bus2 ();

    assign bus0.wave_sel = sel;
    assign bus1.wave_sel = sel;
    assign bus2.wave_sel = sel;

    wave_ctrl_dds #(.FREQ_CTRL(F0), .PHASE_CTRL(8'd0))  dut0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0.slave));
    wave_ctrl_dds #(.FREQ_CTRL(F0), .PHASE_CTRL(8'd64)) dut1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus1.slave));
    wave_ctrl_dds #(.FREQ_CTRL(F2), .PHASE_CTRL(8'd0))  dut2 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus2.slave));

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  q2[$];
    logic [31:0] acc0, acc1, acc2;
    logic [3:0]  s1, s2;
    int          passed = 0;
    int          total  = 0;

    function automatic logic [7:0] ref_wave(input logic [3:0] s, input logic [7:0] i);
        real v;
        case (s)
            4'b0001: begin
                v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0);
                return 8'($rtoi(v + 0.5));
            end
            4'b0010: return (i < 8'd128) ? 8'd255 : 8'd0;
            4'b0100: return (i < 8'd128) ? 8'(2 * int'(i)) : 8'(2 * (255 - int'(i)));
            4'b1000: return i;
            default: return 8'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // One clock of stimulus: inputs set at the falling edge, expectation for the next rising edge queued
    task automatic drive(input logic r, input logic [3:0] s);
        logic [3:0] eff;
        @(negedge sys_clk);
        sys_rst = r;
        sel     = s;
        if (r) begin
            q0.push_back(8'd0); q1.push_back(8'd0); q2.push_back(8'd0);
            acc0 = 32'd0; acc1 = 32'd0; acc2 = 32'd0;
            s1 = 4'b0000; s2 = 4'b0000;
        end else begin
            eff = (SEL_DLY == 0) ? s : s2;
            q0.push_back(ref_wave(eff, acc0[31:24]));
            q1.push_back(ref_wave(eff, acc1[31:24] + 8'd64));
            q2.push_back(ref_wave(eff, acc2[31:24]));
            acc0 = acc0 + F0; acc1 = acc1 + F0; acc2 = acc2 + F2;
            s2 = s1; s1 = s;
        end
    endtask

    always @(posedge sys_clk) begin
        #1;
        if (q0.size() > 0) check("dut0_sample", bus0.dac_data, q0.pop_front());
        if (q1.size() > 0) check("dut1_offset_sample", bus1.dac_data, q1.pop_front());
        if (q2.size() > 0) check("dut2_nominal_sample", bus2.dac_data, q2.pop_front());
    end

    initial begin
        logic [3:0] steps [7];
        steps = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0000, 4'b1000};
        sys_rst = 1'b1;
        sel     = 4'b0001;

        repeat (2) drive(1'b1, 4'b0001);
        repeat (256) drive(1'b0, 4'b0001);
        repeat (257) drive(1'b0, 4'b1000);
        repeat (256) drive(1'b0, 4'b0010);
        repeat (256) drive(1'b0, 4'b0100);
        foreach (steps[k]) repeat (6) drive(1'b0, steps[k]);

        // Asynchronous assertion away from any clock edge must clear the outputs at once
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b1;
        #1;
        check("async_rst_dut0", bus0.dac_data, 8'd0);
        check("async_rst_dut1", bus1.dac_data, 8'd0);
        check("async_rst_dut2", bus2.dac_data, 8'd0);
        repeat (2) drive(1'b1, 4'b1000);
        repeat (10) drive(1'b0, 4'b0001);

        repeat (2) @(posedge sys_clk);
        #2;
        total++;
        if ((q0.size() + q1.size() + q2.size()) == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q0.size() + q1.size() + q2.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
